// File: rtl/scard_rx_engine.sv
// scard_rx_engine: ISO 7816-3 character receiver with oversampled majority filter and one-entry output register
module scard_rx_engine #(
  parameter int OVERSAMPLE = 8,
  parameter int DIV_WIDTH  = 16,
  parameter int DATA_BITS  = 8,
  parameter int IDLE_TICKS = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rxd,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 inverse_conv,
  input  logic                 two_stop,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun,
  output logic                 rx_idle,
  output logic                 rx_eop
);
  localparam int PW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int GW = $clog2(IDLE_TICKS + 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, stateNext;
  logic [DIV_WIDTH-1:0] divCnt;
  logic [1:0] syncReg;
  logic [2:0] samp;
  logic [PW-1:0] phase, phaseLast;
  logic [BW-1:0] bitCnt;
  logic [DATA_BITS-1:0] shiftReg;
  logic [GW-1:0] gap;
  logic tick, filt, bitVal, phaseEnd, startDet, done, load;
  logic cfgPar, cfgOdd, cfgInv, cfgTwo, parAcc, frmAcc, stopCnt;
  assign tick      = divCnt == baud_div;
  assign filt      = (samp[0] & samp[1]) | (samp[0] & samp[2]) | (samp[1] & samp[2]);
  assign bitVal    = filt ^ cfgInv;
  assign phaseLast = state == START ? PW'(OVERSAMPLE / 2 - 1) : PW'(OVERSAMPLE - 1);
  assign phaseEnd  = phase == phaseLast;
  assign startDet  = tick && state == IDLE && !filt;
  assign load      = done && (!rx_valid || rx_ready);
  assign rx_idle   = gap == GW'(IDLE_TICKS);
  always_comb begin
    stateNext = state;
    done      = 1'b0;
    if (tick) begin
      case (state)
        IDLE:    stateNext = filt ? IDLE : START;
        START:   if (phaseEnd) stateNext = filt ? IDLE : DATA;
        DATA:    if (phaseEnd && bitCnt == BW'(DATA_BITS - 1)) stateNext = cfgPar ? PARITY : STOP;
        PARITY:  if (phaseEnd) stateNext = STOP;
        STOP: begin
          if (phaseEnd && (!cfgTwo || stopCnt)) begin
            stateNext = IDLE;
            done      = 1'b1;
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= stateNext;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      divCnt   <= '0;
      syncReg  <= 2'b11;
      samp     <= 3'b111;
      phase    <= '0;
      bitCnt   <= '0;
      shiftReg <= '0;
      stopCnt  <= 1'b0;
      parAcc   <= 1'b0;
      frmAcc   <= 1'b0;
      cfgPar   <= 1'b0;
      cfgOdd   <= 1'b0;
      cfgInv   <= 1'b0;
      cfgTwo   <= 1'b0;
    end else begin
      divCnt  <= tick ? '0 : divCnt + 1'b1;
      syncReg <= {syncReg[0], rxd};
      if (tick) begin
        samp  <= {samp[1:0], syncReg[1]};
        phase <= (state == IDLE || phaseEnd) ? '0 : phase + 1'b1;
      end
      if (startDet) begin
        cfgPar  <= parity_en;
        cfgOdd  <= parity_odd;
        cfgInv  <= inverse_conv;
        cfgTwo  <= two_stop;
        bitCnt  <= '0;
        stopCnt <= 1'b0;
        parAcc  <= 1'b0;
        frmAcc  <= 1'b0;
      end
      if (tick && phaseEnd && state == DATA) begin
        shiftReg <= cfgInv ? {shiftReg[DATA_BITS-2:0], bitVal} : {bitVal, shiftReg[DATA_BITS-1:1]};
        bitCnt   <= bitCnt + 1'b1;
      end
      if (tick && phaseEnd && state == PARITY) parAcc <= (^shiftReg ^ bitVal) != cfgOdd;
      if (tick && phaseEnd && state == STOP) begin
        frmAcc  <= frmAcc | !filt;
        stopCnt <= 1'b1;
      end
    end
  end
  // the final stop sample is folded into the frame flag on the same edge it loads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
      rx_eop        <= 1'b0;
      gap           <= GW'(IDLE_TICKS);
    end else begin
      if (load) begin
        rx_data       <= shiftReg;
        rx_parity_err <= parAcc;
        rx_frame_err  <= frmAcc | !filt;
      end
      rx_valid   <= load | (rx_valid & !rx_ready);
      rx_overrun <= done & !load;
      rx_eop     <= state == IDLE && tick && gap == GW'(IDLE_TICKS - 1);
      if (state != IDLE) gap <= '0;
      else if (tick && !rx_idle) gap <= gap + 1'b1;
    end
  end
endmodule
